if_fetch_stage: RTL and testbench

- Instruction-fetch stage: owns the PC register, drives the instruction-memory request handshake, and holds the IF/ID pipeline register.
- Consumes PCwrite/stall from the hazard detection unit and flush/branch_target from the branch resolution logic.
- Feeds the decode stage, and through it the hazard unit's rs1/rs2 fields.
- Contains a 1-entry skid buffer so a response arriving during a stall is never lost.

---
 rtl/if_fetch_stage_pkg.sv | 20 ++
 rtl/if_fetch_stage_if.sv | 32 +++
 rtl/if_fetch_stage_if_id_reg.sv | 52 +++++
 rtl/if_fetch_stage.sv | 155 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage_pkg
// Description : Shared pipeline constants and the fetch-state encoding used
//               by the instruction-fetch stage and its IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_stage_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    // Fetch state encoding
    localparam logic [1:0] FETCH = 2'd0;   // request in flight
    localparam logic [1:0] HOLD  = 2'd1;   // skid full, waiting for stall to drop
    localparam logic [1:0] DRAIN = 2'd2;   // finishing a request abandoned by a flush

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage_if
// Description : Instruction-memory request/response bundle. The fetch stage
//               is the master; the instruction memory is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_stage_if #(
    parameter int XLEN = if_fetch_stage_pkg::XLEN
);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/if_fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : Pipeline register between fetch and decode. Squash inserts a
//               bubble and wins over hold; hold keeps the current contents.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter int              XLEN      = if_fetch_stage_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_hold,
    input  wire logic            i_squash,
    input  wire logic [XLEN-1:0] i_pc,
    input  wire logic [XLEN-1:0] i_instr,
    input  wire logic            i_valid,
    output logic      [XLEN-1:0] o_pc,
    output logic      [XLEN-1:0] o_instr,
    output logic                 o_valid
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_valid;

    // Capture, hold or squash the decode-stage instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_squash) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= i_valid;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage. Owns the PC, runs the instruction
//               memory handshake, parks a response in a 1-entry skid buffer
//               while decode is stalled, and drains abandoned requests after
//               a branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int              XLEN      = if_fetch_stage_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = if_fetch_stage_pkg::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            PCwrite,
    input  wire logic            stall,
    input  wire logic            flush,
    input  wire logic [XLEN-1:0] branch_target,
    if_fetch_stage_if.master     imem,
    output logic      [XLEN-1:0] if_id_pc,
    output logic      [XLEN-1:0] if_id_instr,
    output logic                 if_id_valid,
    output logic      [XLEN-1:0] pc_out
);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_skid_instr;

    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_req_nxt;
    logic            w_skid_load;
    logic            w_ifid_hold;
    logic            w_ifid_squash;
    logic [XLEN-1:0] w_ifid_pc;
    logic [XLEN-1:0] w_ifid_instr;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_inc;

    // Redirect targets are word aligned; the low two bits are dropped
    assign w_target = branch_target & ~XLEN'(3);
    // Wraps modulo 2^XLEN
    assign w_pc_inc = r_pc + XLEN'(4);

    // No request while reset is held or while the skid buffer is occupied
    assign imem.imem_req  = !rst && (r_state != HOLD);
    assign imem.imem_addr = r_req_addr;
    assign pc_out         = r_pc;

    // Next-state, PC and IF/ID control; flush outranks stall and PCwrite
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_req_nxt     = r_req_addr;
        w_skid_load   = 1'b0;
        w_ifid_hold   = 1'b1;
        w_ifid_squash = 1'b0;
        w_ifid_pc     = r_req_addr;
        w_ifid_instr  = imem.imem_rdata;
        if (flush) begin
            w_ifid_squash = 1'b1;
            w_pc_nxt      = w_target;
            // An outstanding request must complete before the new address goes out
            if ((r_state != HOLD) && !imem.imem_ready) begin
                w_state_nxt = DRAIN;
            end else begin
                w_req_nxt   = w_target;
                w_state_nxt = FETCH;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem.imem_ready) begin
                        if (stall) begin
                            w_skid_load = 1'b1;
                            w_state_nxt = HOLD;
                        end else begin
                            w_ifid_hold = 1'b0;
                            if (PCwrite) begin
                                w_pc_nxt  = w_pc_inc;
                                w_req_nxt = w_pc_inc;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        w_ifid_hold  = 1'b0;
                        w_ifid_pc    = r_skid_pc;
                        w_ifid_instr = r_skid_instr;
                        w_state_nxt  = FETCH;
                        if (PCwrite) begin
                            w_pc_nxt  = w_pc_inc;
                            w_req_nxt = w_pc_inc;
                        end
                    end
                end
                DRAIN: begin
                    // Stale data is dropped; the redirect target is already in pc
                    if (imem.imem_ready) begin
                        w_req_nxt   = r_pc;
                        w_state_nxt = FETCH;
                    end
                end
                default: begin
                    w_state_nxt = FETCH;
                end
            endcase
        end
    end

    // Fetch state, PC, request address and skid buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_nxt;
            if (w_skid_load) begin
                r_skid_pc    <= r_req_addr;
                r_skid_instr <= imem.imem_rdata;
            end
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (w_ifid_hold),
        .i_squash (w_ifid_squash),
        .i_pc     (w_ifid_pc),
        .i_instr  (w_ifid_instr),
        .i_valid  (1'b1),
        .o_pc     (if_id_pc),
        .o_instr  (if_id_instr),
        .o_valid  (if_id_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Self-checking bench for if_fetch_stage. A behavioural
//               instruction memory answers requests with rdata = 0xA0 + addr
//               after a programmable number of wait states; accepted
//               responses are queued and matched against IF/ID updates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCwrite;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] pc_out;

    if_fetch_stage_if #(.XLEN(32)) bus ();

    if_fetch_stage #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (c_nop)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PCwrite       (PCwrite),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem          (bus),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .pc_out        (pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          mem_wait = 0;
    int          wait_cnt = 0;
    bit          drain_pending = 1'b0;
    logic [31:0] last_instr = 32'hFFFF_FFFF;

    // One clock: memory answers, scoreboard records, IF/ID update is matched
    task automatic cycle();
        exp_t e;
        if (bus.imem_req === 1'b1) begin
            if (wait_cnt >= mem_wait) begin
                bus.imem_ready = 1'b1;
                bus.imem_rdata = 32'hA0 + bus.imem_addr;
                wait_cnt = 0;
            end else begin
                bus.imem_ready = 1'b0;
                bus.imem_rdata = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end else begin
            bus.imem_ready = 1'b0;
            bus.imem_rdata = 32'hDEAD_BEEF;
            wait_cnt = 0;
        end
        if (flush) begin
            drain_pending = (bus.imem_req === 1'b1) && !bus.imem_ready;
        end else if (bus.imem_ready) begin
            if (drain_pending) drain_pending = 1'b0;
            else sb.push_back('{bus.imem_addr, bus.imem_rdata});
        end
        @(posedge clk);
        #1;
        if (if_id_valid === 1'b1 && if_id_instr !== last_instr) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h required no update", if_id_pc, if_id_instr);
            end else begin
                e = sb.pop_front();
                if (if_id_pc !== e.pc || if_id_instr !== e.instr) begin
                    errors++;
                    $display("FAIL sb_entry: got pc=%h instr=%h required pc=%h instr=%h",
                             if_id_pc, if_id_instr, e.pc, e.instr);
                end
            end
            last_instr = if_id_instr;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; PCwrite = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0;
        bus.imem_ready = 1'b0; bus.imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", bus.imem_req); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", if_id_valid); end
        checks++; if (if_id_instr !== c_nop) begin errors++; $display("FAIL rst_instr: got %h required %h", if_id_instr, c_nop); end
        checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL rst_ifid_pc: got %h required 0", if_id_pc); end
        checks++; if (pc_out !== 32'h0 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL rst_pc: got pc=%h addr=%h required 0/0", pc_out, bus.imem_addr); end
        rst = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rst_release_req: got %b required 1", bus.imem_req); end
    endtask

    task automatic test_zero_wait();
        mem_wait = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * i)) begin
                errors++; $display("FAIL zw_addr: got req=%b addr=%h required 1/%h", bus.imem_req, bus.imem_addr, 32'(4 * i));
            end
            cycle();
            checks++;
            if (if_id_valid !== 1'b1) begin errors++; $display("FAIL zw_valid: got %b required 1", if_id_valid); end
        end
        checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL zw_pc_out: got %h required 8", pc_out); end
    endtask

    task automatic test_stall();
        checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL st_addr: got %h required 8", bus.imem_addr); end
        stall = 1'b1; PCwrite = 1'b0;
        cycle();
        checks++; if (if_id_pc !== 32'h4 || if_id_instr !== 32'hA4) begin
            errors++; $display("FAIL st_hold_ifid: got pc=%h instr=%h required 4/a4", if_id_pc, if_id_instr); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL st_hold_req: got %b required 0", bus.imem_req); end
        cycle();
        checks++; if (bus.imem_req !== 1'b0 || if_id_pc !== 32'h4) begin
            errors++; $display("FAIL st_hold2: got req=%b pc=%h required 0/4", bus.imem_req, if_id_pc); end
        stall = 1'b0; PCwrite = 1'b1;
        cycle();
        checks++; if (if_id_pc !== 32'h8 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL st_release_ifid: got pc=%h valid=%b required 8/1", if_id_pc, if_id_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin
            errors++; $display("FAIL st_next_req: got req=%b addr=%h required 1/c", bus.imem_req, bus.imem_addr); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL st_sb_empty: got %0d entries required 0", sb.size()); end
    endtask

    task automatic test_wait_states();
        logic [31:0] a;
        mem_wait = 2;
        for (int r = 0; r < 2; r++) begin
            a = 32'hC + 32'(4 * r);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== a || if_id_pc !== a - 32'h4) begin
                    errors++;
                    $display("FAIL ws_hold: got req=%b addr=%h ifid_pc=%h required 1/%h/%h",
                             bus.imem_req, bus.imem_addr, if_id_pc, a, a - 32'h4);
                end
                cycle();
            end
        end
        checks++; if (if_id_pc !== 32'h10 || sb.size() != 0) begin
            errors++; $display("FAIL ws_end: got pc=%h sb=%0d required 10/0", if_id_pc, sb.size()); end
    endtask

    task automatic test_flush_drain();
        bit seen = 1'b0;
        checks++; if (bus.imem_addr !== 32'h14) begin errors++; $display("FAIL fd_addr: got %h required 14", bus.imem_addr); end
        flush = 1'b1; branch_target = 32'h0000_0103;
        cycle();
        flush = 1'b0;
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== c_nop) begin
            errors++; $display("FAIL fd_squash: got valid=%b instr=%h required 0/%h", if_id_valid, if_id_instr, c_nop); end
        checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL fd_pc_out: got %h required 100", pc_out); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h14) begin
            errors++; $display("FAIL fd_drain_addr: got req=%b addr=%h required 1/14", bus.imem_req, bus.imem_addr); end
        for (int n = 0; n < 8; n++) begin
            if (bus.imem_addr === 32'h100) begin
                seen = 1'b1;
                break;
            end
            cycle();
        end
        checks++; if (!seen) begin errors++; $display("FAIL fd_redirect: got addr=%h required 100 within 8 cycles", bus.imem_addr); end
        checks++; if (if_id_valid !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL fd_discard: got valid=%b sb=%0d required 0/0", if_id_valid, sb.size()); end
    endtask

    task automatic test_flush_stall();
        mem_wait = 0;
        stall = 1'b1; flush = 1'b1; branch_target = 32'h0000_0200;
        cycle();
        stall = 1'b0; flush = 1'b0;
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== c_nop) begin
            errors++; $display("FAIL fs_squash: got valid=%b instr=%h required 0/%h", if_id_valid, if_id_instr, c_nop); end
        checks++; if (pc_out !== 32'h200 || bus.imem_addr !== 32'h200 || bus.imem_req !== 1'b1) begin
            errors++; $display("FAIL fs_redirect: got pc=%h addr=%h req=%b required 200/200/1", pc_out, bus.imem_addr, bus.imem_req); end
    endtask

    task automatic test_wrap();
        flush = 1'b1; branch_target = 32'hFFFF_FFFC;
        cycle();
        flush = 1'b0;
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_target: got %h required fffffffc", bus.imem_addr); end
        cycle();
        checks++; if (if_id_pc !== 32'hFFFF_FFFC || bus.imem_addr !== 32'h0 || pc_out !== 32'h0) begin
            errors++; $display("FAIL wr_wrap: got ifid_pc=%h addr=%h pc=%h required fffffffc/0/0", if_id_pc, bus.imem_addr, pc_out); end
        cycle();
        checks++; if (if_id_pc !== 32'h0 || if_id_instr !== 32'hA0 || sb.size() != 0) begin
            errors++; $display("FAIL wr_after: got pc=%h instr=%h sb=%0d required 0/a0/0", if_id_pc, if_id_instr, sb.size()); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_wait_states();
        test_flush_drain();
        test_flush_stall();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
